// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the adder-sharing arbiter slice.
package adder_arb_pkg;
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  localparam int ADD_W = 63;
  localparam int SUM_W = 64;

  // Low bit of requester idx inside a packed operand bus.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any_gnt
);
  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!any_gnt && req[idx]) begin
        any_gnt  = 1'b1;
        gnt_idx  = ID_W'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/unsignedRippleCarryAdder63bit.sv
// Unsigned ripple-carry adder; the sum carries one extra bit for the carry-out.
module unsignedRippleCarryAdder63bit
  import adder_arb_pkg::*;
#(
  parameter int W = ADD_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);
  logic carry;

  always_comb begin
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    sum[W] = carry;
  end
endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin share of one ripple-carry adder among N_REQ valid/ready requesters.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = ADD_W,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W:0]         rsp_sum,
  output logic [ID_W-1:0]    rsp_id,
  output logic               busy
);
  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, ptr_nxt, tag, gnt_idx;
  logic [N_REQ-1:0] req_eff, gnt_oh;
  logic             any_gnt, accept;
  logic [W-1:0]     op_a, op_b, a_sel, b_sel;
  logic [W:0]       add_sum;

  // A new operation may start only when the output slot is free or being drained.
  assign accept  = (state == IDLE) || (state == RESP && rsp_ready);
  assign req_eff = accept ? req_valid : '0;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req     (req_eff),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // State is IDLE during reset, so mask ready explicitly while rst_n is low.
  assign req_ready = rst_n ? gnt_oh : '0;
  assign a_sel     = req_a[slice_lo(int'(gnt_idx), W) +: W];
  assign b_sel     = req_b[slice_lo(int'(gnt_idx), W) +: W];
  assign ptr_nxt   = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + ID_W'(1);

  unsignedRippleCarryAdder63bit #(.W(W)) u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (add_sum)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_gnt) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = any_gnt ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      op_a    <= '0;
      op_b    <= '0;
      tag     <= '0;
      rsp_sum <= '0;
      rsp_id  <= '0;
    end else begin
      state <= state_nxt;
      if (any_gnt) begin
        op_a   <= a_sel;
        op_b   <= b_sel;
        tag    <= gnt_idx;
        rr_ptr <= ptr_nxt;
      end
      if (state == CALC) begin
        rsp_sum <= add_sum;
        rsp_id  <= tag;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
endmodule
